load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory port. Accepts byte/halfword/word load and store requests from the CPU datapath with byte addresses, and drives a word-addressed, word-wide memory: asynchronous read and posedge write of a full word. Performs address checking, byte-lane extraction with sign/zero extension on loads, and read-modify-write for sub-word stores. Returns one response per request over a valid/ready handshake.

## Interface
- DEPTH, 1024, memory size in 32-bit words; word index must be < DEPTH
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit idle, request accepted when req_valid && req_ready at posedge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed when resp_valid && resp_ready at posedge
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_error  out  1  misaligned, illegal size, or word index ≥ DEPTH
- mem_addr  out  32  word index = latched req_addr[31:2], zero-extended
- mem_we  out  1  memory write enable
- mem_wdata  out  32  full word written to memory
- mem_rdata  in  32  memory read data, combinational from mem_addr

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: req_ready=1. On accept, latch write/size/signed/addr/wdata. Next state:
  - error (size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:2] ≥ DEPTH) → RESP, resp_error=1, no memory access.
  - load → LOAD.
  - store word → WRITE, mem_wdata = wdata.
  - store byte/half → RMW_READ.
- LOAD: mem_addr driven; at posedge capture lane from mem_rdata → RESP.
  - lanes little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half at addr[1]=0 → [15:0], addr[1]=1 → [31:16].
  - extend to 32 bits per req_signed; word loads pass through unmodified.
- RMW_READ: capture mem_rdata, replace addressed lane(s) with wdata[7:0] or wdata[15:0] → WRITE.
- WRITE: mem_we=1 for exactly this one cycle, mem_wdata = merged or full word → RESP.
- RESP: resp_valid=1, outputs stable until accepted; on accept → IDLE. No new request accepted in the same cycle (req_ready=0 outside IDLE).
- mem_we is 0 in every state except WRITE. mem_addr holds last latched index outside active states.

## Timing
- Accept at edge N (cycle N in IDLE). resp_valid first high in cycle:
  - error: N+1
  - word load, word store: N+2
  - byte/half load: N+2
  - byte/half store: N+3
- Back-to-back throughput: one request per (latency + 1) cycles when resp_ready held high; RESP→IDLE costs one cycle.
- resp_ready low stalls in RESP indefinitely; no memory activity during the stall.
- Reset (reset_n low, any cycle): immediately state=IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, all latches cleared. A WRITE in progress is dropped if reset_n falls before its write edge. An in-flight request is abandoned with no response.
- Index DEPTH-1 is legal; DEPTH and above error. Address bits [1:0] are never forwarded to memory.

## Test plan
- Reset mid-RMW: store byte to 0x10 and assert reset_n=0 during RMW_READ → mem_we never pulses, req_ready=1 immediately, memory word 4 unchanged.
- Word store/load: store 0xDEADBEEF to addr 0x8, then load word 0x8 → mem_we pulses once at mem_addr=2, response in N+2, resp_rdata=0xDEADBEEF, resp_error=0.
- Sub-word store merge: word 3 = 0x11223344; store byte 0xAB to 0xE → word 3 = 0x11AB3344, one mem_we pulse, resp in N+3. Store half 0xCAFE to 0xC → 0x11ABCAFE.
- Extension: word 5 = 0x80FF7F01; byte load 0x15 signed → 0x0000007F; byte 0x17 signed → 0xFFFFFF80; half 0x16 unsigned → 0x000080FF; half 0x16 signed → 0xFFFF80FF.
- Errors: word load 0x6, half store 0x3, size 11, word load 0x1000 (index 1024) → resp_error=1 at N+1, resp_rdata=0, mem_we stays 0; load 0xFFC (index 1023) succeeds.
- Backpressure: resp_ready=0 for 5 cycles after a load → resp_valid, resp_rdata stable, req_ready=0; req_valid held high is not accepted until cycle after resp accept.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-memory initiator: byte/half/word loads and stores over a word-wide memory,
// with address checking, lane extraction/extension and read-modify-write for sub-word stores.
module load_store_unit #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      RMW_READ = 3'd2,
      WRITE    = 3'd3,
      RESP     = 3'd4
   } state_t;

   localparam logic [29:0] DEPTH_IDX = 30'(DEPTH);

   state_t      state_r;
   logic [1:0]  size_r;
   logic        signed_r;
   logic [1:0]  off_r;
   logic [31:0] wdata_r;

   function automatic logic is_error(input logic [1:0] size, input logic [31:0] addr);
      logic err;
      case (size)
         2'b00:   err = 1'b0;
         2'b01:   err = addr[0];
         2'b10:   err = (addr[1:0] != 2'b00);
         default: err = 1'b1;
      endcase
      err = err | (addr[31:2] >= DEPTH_IDX);
      return err;
   endfunction

   // Little-endian lane select followed by sign or zero extension; words pass through.
   function automatic logic [31:0] extract_lane(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'b00:   b = rdata[7:0];
         2'b01:   b = rdata[15:8];
         2'b10:   b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (size)
         2'b00:   res = {{24{sgn & b[7]}}, b};
         2'b01:   res = {{16{sgn & h[15]}}, h};
         default: res = rdata;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] res;
      res = old;
      case (size)
         2'b00: begin
            case (off)
               2'b00:   res[7:0]   = wdata[7:0];
               2'b01:   res[15:8]  = wdata[7:0];
               2'b10:   res[23:16] = wdata[7:0];
               default: res[31:24] = wdata[7:0];
            endcase
         end
         2'b01: begin
            if (off[1]) res[31:16] = wdata[15:0];
            else        res[15:0]  = wdata[15:0];
         end
         default: res = wdata;
      endcase
      return res;
   endfunction

   // Control FSM; every output is registered so it is glitch-free and stable in RESP.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         size_r     <= 2'b00;
         signed_r   <= 1'b0;
         off_r      <= 2'b00;
         wdata_r    <= 32'h0000_0000;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0000_0000;
         resp_error <= 1'b0;
         mem_addr   <= 32'h0000_0000;
         mem_we     <= 1'b0;
         mem_wdata  <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  size_r    <= req_size;
                  signed_r  <= req_signed;
                  off_r     <= req_addr[1:0];
                  wdata_r   <= req_wdata;
                  if (is_error(req_size, req_addr)) begin
                     // Faulting requests never touch memory, so mem_addr keeps its old index.
                     resp_valid <= 1'b1;
                     resp_error <= 1'b1;
                     resp_rdata <= 32'h0000_0000;
                     state_r    <= RESP;
                  end else begin
                     mem_addr <= {2'b00, req_addr[31:2]};
                     if (!req_write) begin
                        state_r <= LOAD;
                     end else if (req_size == 2'b10) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= req_wdata;
                        state_r   <= WRITE;
                     end else begin
                        state_r <= RMW_READ;
                     end
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            LOAD: begin
               resp_rdata <= extract_lane(mem_rdata, size_r, signed_r, off_r);
               resp_error <= 1'b0;
               resp_valid <= 1'b1;
               state_r    <= RESP;
            end
            RMW_READ: begin
               mem_wdata <= merge_lane(mem_rdata, wdata_r, size_r, off_r);
               mem_we    <= 1'b1;
               state_r   <= WRITE;
            end
            WRITE: begin
               mem_we     <= 1'b0;
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0000_0000;
               resp_error <= 1'b0;
               state_r    <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= 32'h0000_0000;
                  resp_error <= 1'b0;
                  req_ready  <= 1'b1;
                  state_r    <= IDLE;
               end else begin
                  resp_valid <= 1'b1;
               end
            end
            default: begin
               state_r    <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               mem_we     <= 1'b0;
            end
         endcase
      end
   end

endmodule
